// File: rtl/pipelined_adder_pkg.sv
// Shared sizing helpers for the sliced pipelined adder: pipeline depth and
// the width of each slice (the last slice absorbs the remainder).
package pipelined_adder_pkg;

  function automatic int num_stages(input int width, input int slice);
    return (width + slice - 1) / slice;
  endfunction

  function automatic int slice_width(input int width, input int slice, input int k);
    int last;
    last = num_stages(width, slice) - 1;
    return (k == last) ? (width - last * slice) : slice;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple slice: sum, carry out, and carry into the top bit
// (the latter feeds signed-overflow detection in the final stage).
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] full;

  assign full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  assign s     = full[W-1:0];
  assign co    = full[W];
  // Carry into bit W-1 recovered from the sum bit and its two operand bits.
  assign c_msb = s[W-1] ^ x[W-1] ^ y[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: one slice per stage, carry registered between
// stages, global advance shared by every stage for valid/ready flow control.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = num_stages(WIDTH, SLICE);

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff    = sub ? ~b : b;
  assign c_eff    = cin ^ sub;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO  = gi * SLICE;
    localparam int W   = slice_width(WIDTH, SLICE, gi);
    localparam int RES = LO + W;
    localparam int SW  = WIDTH - LO;
    localparam int REM = WIDTH - RES;

    // Unresolved operand bits entering this stage, LSB-aligned to its slice.
    logic [SW-1:0]  a_src;
    logic [SW-1:0]  b_src;
    logic           c_src;
    logic           v_src;
    logic [RES-1:0] sum_next;
    logic [W-1:0]   s;
    logic           co;
    logic           c_msb;

    logic           valid_reg;
    logic           carry_reg;
    logic [RES-1:0] sum_reg;

    adder_slice #(.W(W)) u_slice (
      .x     (a_src[W-1:0]),
      .y     (b_src[W-1:0]),
      .ci    (c_src),
      .s     (s),
      .co    (co),
      .c_msb (c_msb)
    );

    if (gi == 0) begin : g_head
      assign a_src    = a;
      assign b_src    = b_eff;
      assign c_src    = c_eff;
      assign v_src    = in_valid;
      assign sum_next = s;
    end else begin : g_body
      assign a_src    = g_stage[gi-1].g_keep.a_reg;
      assign b_src    = g_stage[gi-1].g_keep.b_reg;
      assign c_src    = g_stage[gi-1].carry_reg;
      assign v_src    = g_stage[gi-1].valid_reg;
      assign sum_next = {s, g_stage[gi-1].sum_reg};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
      end else if (adv) begin
        valid_reg <= v_src;
        if (v_src) begin
          carry_reg <= co;
          sum_reg   <= sum_next;
        end
      end
    end

    if (REM > 0) begin : g_keep
      logic [REM-1:0] a_reg;
      logic [REM-1:0] b_reg;
      // Only the final stage's top-bit carry is meaningful.
      logic           c_msb_unused;

      assign c_msb_unused = c_msb;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv && v_src) begin
          a_reg <= a_src[SW-1:W];
          b_reg <= b_src[SW-1:W];
        end
      end
    end else begin : g_last
      logic ovf_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (adv && v_src) begin
          ovf_reg <= c_msb ^ co;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign sum       = g_stage[STAGES-1].sum_reg;
  assign cout      = g_stage[STAGES-1].carry_reg;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_reg;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboarded checks of pipelined_adder at 32/8, 13/5 and 16/16.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0, sum;
  logic        cin = 1'b0, sub = 1'b0, cout, ovf;

  logic        v13 = 1'b0, rdy13, ov13, cout13, ovf13;
  logic [12:0] a13 = '0, b13 = '0, sum13;
  logic        cin13 = 1'b0, sub13 = 1'b0;

  logic        v16 = 1'b0, rdy16, ov16, cout16, ovf16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cin16 = 1'b0, sub16 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(13), .SLICE(5)) dut13 (
    .clk(clk), .rst(rst), .in_valid(v13), .in_ready(rdy13),
    .a(a13), .b(b13), .cin(cin13), .sub(sub13),
    .out_valid(ov13), .out_ready(1'b1),
    .sum(sum13), .cout(cout13), .ovf(ovf13)
  );

  pipelined_adder #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(1'b1),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  // Reference: {ovf, cout, sum} for a w-bit add/sub; overflow via the carry into bit w-1.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic sb);
    logic [63:0] mask, m1, xe, ye, full, low;
    logic        ce;
    mask = (64'd1 << w) - 64'd1;
    m1   = mask >> 1;
    xe   = {32'd0, x} & mask;
    ye   = (sb ? ~{32'd0, y} : {32'd0, y}) & mask;
    ce   = ci ^ sb;
    full = xe + ye + {63'd0, ce};
    low  = (xe & m1) + (ye & m1) + {63'd0, ce};
    return {low[w-1] ^ full[w], full[w], full[31:0] & mask[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic sb, output logic [33:0] r);
    logic seen;
    seen = 1'b0;
    r    = '0;
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin
        r    = {ovf, cout, sum};
        seen = 1'b1;
      end
    end
    check("op_timeout", seen, 1'b1);
    $display("op a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b", x, y, ci, sb, r[31:0], r[32], r[33]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] r;
    logic [33:0] exp_q[$];
    logic [33:0] q13[$];
    logic [33:0] q16[$];
    logic [33:0] e;
    logic [31:0] held_sum;
    logic        held_c, held_o, stalled, pending, stale;
    int          sent, got;

    // Reset state while rst is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Back-to-back 0xFFFFFFFF + 1: four accepts, results after exactly three more edges.
    out_ready = 1'b1; in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'd1; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("lat_valid", out_valid, (i >= 3 && i <= 6));
      if (i >= 3 && i <= 6) begin
        check("wrap_result", {ovf, cout, sum}, {1'b0, 1'b1, 32'd0});
        $display("lat edge=%0d sum=%h cout=%b ovf=%b", i, sum, cout, ovf);
      end
      if (i == 3) in_valid = 1'b0;
    end

    // Directed subtract and overflow cases.
    run_op(32'd5, 32'd7, 1'b0, 1'b1, r);
    check("sub_5_7", r, {1'b0, 1'b0, 32'hFFFF_FFFE});
    run_op(32'd5, 32'd7, 1'b1, 1'b1, r);
    check("sub_5_7_borrow", r, {1'b0, 1'b0, 32'hFFFF_FFFD});
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, r);
    check("add_pos_ovf", r, {1'b1, 1'b0, 32'h8000_0000});
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, r);
    check("sub_neg_ovf", r, {1'b1, 1'b1, 32'h7FFF_FFFF});

    // Random stream with random back-pressure.
    sent = 0; got = 0; pending = 1'b0; stalled = 1'b0;
    held_sum = '0; held_c = 1'b0; held_o = 1'b0;
    for (int cyc = 0; cyc < 600 && got < 10; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        check("stall_hold", {ovf, cout, sum}, {held_o, held_c, held_sum});
      end
      if (!pending) in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      if (!pending && sent < 10 && $urandom_range(0, 3) != 0) begin
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1; pending = 1'b1;
      end
      #1;
      check("in_ready_rel", in_ready, (!out_valid || out_ready));
      stalled = out_valid && !out_ready;
      held_sum = sum; held_c = cout; held_o = ovf;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_spurious", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("stream_result", {ovf, cout, sum}, e);
          $display("stream #%0d sum=%h cout=%b ovf=%b", got, sum, cout, ovf);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(32, a, b, cin, sub));
        sent++;
        pending = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("stream_count", got, 10);
    check("stream_no_extra", {out_valid, 32'(exp_q.size())}, 33'd0);

    // Asynchronous reset with operations in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_result", {out_valid, sum}, {1'b1, 32'd3});
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_sum", {ovf, cout, sum}, 34'd0);
    check("async_in_ready", in_ready, 1'b1);
    $display("async reset: out_valid=%b sum=%h in_ready=%b", out_valid, sum, in_ready);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      stale = stale | out_valid;
    end
    check("no_stale_after_rst", stale, 1'b0);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, r);
    check("post_rst_op", r, {1'b0, 1'b0, 32'h2345_678A});

    // Narrow configurations: 13/5 (3-bit last slice) and 16/16 (single stage).
    for (int cyc = 0; cyc < 170; cyc++) begin
      @(negedge clk);
      if (ov13) begin
        if (q13.size() == 0) check("w13_spurious", 1'b1, 1'b0);
        else begin
          e = q13.pop_front();
          check("w13_result", {ovf13, cout13, sum13}, {e[33], e[32], e[12:0]});
        end
      end
      if (ov16) begin
        if (q16.size() == 0) check("w16_spurious", 1'b1, 1'b0);
        else begin
          e = q16.pop_front();
          check("w16_result", {ovf16, cout16, sum16}, {e[33], e[32], e[15:0]});
        end
      end
      if (cyc < 150) begin
        a13 = 13'($urandom); b13 = 13'($urandom);
        cin13 = 1'($urandom_range(0, 1)); sub13 = 1'($urandom_range(0, 1));
        a16 = 16'($urandom); b16 = 16'($urandom);
        cin16 = 1'($urandom_range(0, 1)); sub16 = 1'($urandom_range(0, 1));
        if (cyc == 0) begin
          a13 = 13'h0FFF; b13 = 13'h0001; cin13 = 1'b0; sub13 = 1'b0;
          a16 = 16'h8000; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b1;
        end
        v13 = 1'b1; v16 = 1'b1;
        q13.push_back(model(13, {19'd0, a13}, {19'd0, b13}, cin13, sub13));
        q16.push_back(model(16, {16'd0, a16}, {16'd0, b16}, cin16, sub16));
      end else begin
        v13 = 1'b0; v16 = 1'b0;
      end
    end
    check("w13_drained", q13.size(), 0);
    check("w16_drained", q16.size(), 0);
    $display("narrow configs: 150 operations each compared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor with a carry-in and valid/ready flow control on both sides. Operands are split into SLICE-bit slices. Each pipeline stage resolves one slice and registers its carry into the next stage, so the critical path is one slice rather than the full width. It is the datapath adder for wide-operand units in the design and accepts one operation per cycle when not back-pressured.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits (≥ 2)
- SLICE, 8, bits resolved per pipeline stage (1 ≤ SLICE ≤ WIDTH)
- Derived constant: STAGES = ceil(WIDTH/SLICE), the pipeline depth. The last slice is WIDTH − (STAGES−1)·SLICE bits wide.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  operation accepted when in_valid & in_ready at a clock edge
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (borrow-in when sub=1, see Operation)
- sub  in  1  0: A + B + cin; 1: A + ~B + ~cin
- out_valid  out  1  result held on sum/cout/ovf
- out_ready  in  1  result consumed when out_valid & out_ready at a clock edge
- sum  out  WIDTH  result
- cout  out  1  raw carry out of bit WIDTH−1
- ovf  out  1  signed overflow

## Operation
- Effective operands: b_eff = sub ? ~b : b; c_eff = cin ^ sub.
  - sub=1, cin=0 gives A − B.
  - sub=1, cin=1 gives A − B − 1 (borrow-in).
- Result: {cout, sum} = a + b_eff + c_eff, computed modulo 2^(WIDTH+1).
- ovf = carry into bit WIDTH−1 XOR cout, i.e. set when the signed result does not fit in WIDTH bits.
- Stage 0 adds slice 0 with c_eff.
- Stage k adds slice k of the registered operands using the registered carry from stage k−1.
- Each stage register holds:
  - a valid bit and the stage carry;
  - the already-resolved low sum bits;
  - the still-unresolved high bits of a and b_eff.
- cout and ovf are produced in the final stage.
- Flow control uses a global advance: adv = !out_valid | out_ready.
  - in_ready = adv, a combinational path from out_ready.
  - When adv=1, every stage loads from its predecessor, and stage 0 loads {in_valid, operands}.
  - When adv=0, every stage holds.
- Bubbles (valid=0) propagate like data. Data registers of invalid stages may hold stale values; only the valid bits are significant.
- While out_valid=0, sum/cout/ovf are don't-care. The implementation still updates them only on valid loads.

## Timing
- Latency: an operation accepted at edge n is presented with out_valid=1 after edge n+STAGES−1, when STAGES > 1 and the pipeline is not stalled. With STAGES=1 it appears after edge n.
- Throughput: 1 operation per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - sum/cout/ovf and all stage contents are stable;
  - in_ready=0;
  - no input is accepted.
- An accept and a consume in the same cycle are legal and lose nothing.
- Reset (asynchronous, any time, including mid-stream):
  - all valid bits clear immediately; out_valid=0;
  - sum=0, cout=0, ovf=0;
  - in_ready=1, since out_valid=0;
  - in-flight operations are discarded;
  - the first edge after rst deasserts may accept.
- The input side must hold a/b/cin/sub stable while in_valid=1 and in_ready=0. The block does not check this.

## Structure
- Package pipelined_adder_pkg holds:
  - a function for the number of stages from WIDTH and SLICE;
  - a function for the width of slice k.
- Sub-module adder_slice is purely combinational, parameter W:
  - inputs x[W], y[W], ci;
  - outputs s[W], co, and c_msb (carry into the top bit, used for ovf in the last stage).
- adder_slice is instantiated once per stage via generate.
- The top level holds the stage registers, the valid chain and adv.

## Test plan
- WIDTH=32, SLICE=8, back-to-back a=0xFFFF_FFFF, b=1, cin=0, sub=0, out_ready=1 → sum=0, cout=1, ovf=0, out_valid exactly 3 edges after accept; one result per cycle thereafter.
- sub=1, cin=0, a=5, b=7 → sum=0xFFFF_FFFE, cout=0, ovf=0. sub=1, cin=1, a=5, b=7 → sum=0xFFFF_FFFD.
- a=0x7FFF_FFFF, b=1, sub=0 → sum=0x8000_0000, ovf=1. a=0x8000_0000, b=1, sub=1 → sum=0x7FFF_FFFF, ovf=1, cout=1.
- Stream 10 random operations while out_ready toggles randomly → every result matches the reference model, in order, none dropped or duplicated; outputs stable during stalls.
- Assert rst with 3 operations in flight → out_valid=0, sum=0 immediately, in_ready=1; no stale result appears after release.
- WIDTH=13, SLICE=5 (last slice 3 bits) and WIDTH=SLICE=16 (STAGES=1) → exhaustive-random comparison against the reference model; cout and ovf correct.
